treeval_ctrl: RTL

TREEVAL_CTRL -- requirements
Module: treeval_ctrl

---
 rtl/treeval_pkg.sv | 29 ++
 rtl/treeval_wait_mon.sv | 45 ++++
 rtl/treeval_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/treeval_pkg.sv
// Shared widths, node_data field layout and controller state encoding for treeval_ctrl.
package treeval_pkg;

  localparam int W_ADDR   = 10;
  localparam int W_ACTION = 3;
  localparam int W_REWARD = 12;
  localparam int W_WEIGHT = 7;
  localparam int W_PARENT = W_ADDR;
  localparam int W_NODE   = 32;
  localparam int W_DATA   = W_REWARD;

  // node_data = parent[31:22] | action[21:19] | reward[18:7] | weight[6:0]
  localparam int OFF_WEIGHT = 0;
  localparam int OFF_REWARD = 7;
  localparam int OFF_ACTION = 19;
  localparam int OFF_PARENT = 22;

  typedef enum logic [2:0] {
    IDLE,
    CONF,
    LOAD,
    WR_W,
    WR_P,
    WR_R,
    WR_A,
    WAIT
  } state_t;

endpackage

// File: rtl/treeval_wait_mon.sv
// Result watcher for the WAIT phase: exp_change rising-edge detect, pass skipping
// and a down-counting timeout that reloads whenever the monitor is disabled.
module treeval_wait_mon #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SKIP_PASSES    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic exp_change,
  output logic hit,
  output logic expire
);

  localparam int PW = $clog2(SKIP_PASSES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          chg_q;
  logic          chg_rise;
  logic [PW-1:0] passes;
  logic [TW-1:0] timer;

  // The edge register samples continuously so a level already high on entry is not an edge.
  assign chg_rise = exp_change & ~chg_q;
  assign hit      = enable & chg_rise & (passes == PW'(SKIP_PASSES));
  assign expire   = enable & (timer == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chg_q  <= 1'b0;
      passes <= '0;
      timer  <= '0;
    end else begin
      chg_q <= exp_change;
      if (!enable) begin
        passes <= '0;
        timer  <= TW'(TIMEOUT_CYCLES - 1);
      end else begin
        if (chg_rise && (passes != PW'(SKIP_PASSES))) passes <= passes + PW'(1);
        if (timer != '0) timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: rtl/treeval_ctrl.sv
// Loads a packed node list into the treeval evaluator field by field, then waits
// for the evaluator result (skipping early passes) with a timeout.
//
// state | meaning
// IDLE  | waiting for cmd_start
// CONF  | node-count configuration write
// LOAD  | node_ready high, waiting for a node word
// WR_W  | weight field write
// WR_P  | parent field write
// WR_R  | reward field write
// WR_A  | action field write, then next node or WAIT
// WAIT  | waiting for evaluator result or timeout
module treeval_ctrl
  import treeval_pkg::*;
#(
  parameter int MAX_NODES      = 1024,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SKIP_PASSES    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic [W_ADDR-1:0]   cmd_nodes,
  input  logic                node_valid,
  output logic                node_ready,
  input  logic [W_ADDR-1:0]   node_addr,
  input  logic [W_NODE-1:0]   node_data,
  output logic                tv_mem_weight,
  output logic                tv_mem_par,
  output logic                tv_mem_rew,
  output logic                tv_mem_act,
  output logic [W_ADDR-1:0]   tv_mem_addr,
  output logic [W_DATA-1:0]   tv_mem_data,
  output logic                tv_conf_nodes,
  output logic [W_ADDR-1:0]   tv_conf_data,
  input  logic                tv_exp_change,
  input  logic [W_REWARD-1:0] tv_exp,
  input  logic [W_ACTION-1:0] tv_act,
  output logic                res_valid,
  output logic [W_REWARD-1:0] res_exp,
  output logic [W_ACTION-1:0] res_act,
  output logic                busy,
  output logic                err
);

  state_t              state, state_nxt;
  logic [W_ADDR-1:0]   count;
  logic [W_ADDR-1:0]   nodes_done;
  logic [W_ADDR-1:0]   addr_q;
  logic [W_NODE-1:0]   word_q;
  logic                cnt_ok;
  logic                start_ok;
  logic                accept;
  logic                capture;
  logic                err_set;
  logic                hit;
  logic                expire;

  assign cnt_ok = (cmd_nodes >= W_ADDR'(2)) && (32'(cmd_nodes) <= 32'(MAX_NODES - 1));
  assign busy   = (state != IDLE);

  treeval_wait_mon #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SKIP_PASSES   (SKIP_PASSES)
  ) u_wait_mon (
    .clk       (clk),
    .rst       (rst),
    .enable    (state == WAIT),
    .exp_change(tv_exp_change),
    .hit       (hit),
    .expire    (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    node_ready    = 1'b0;
    tv_mem_weight = 1'b0;
    tv_mem_par    = 1'b0;
    tv_mem_rew    = 1'b0;
    tv_mem_act    = 1'b0;
    tv_mem_addr   = '0;
    tv_mem_data   = '0;
    tv_conf_nodes = 1'b0;
    tv_conf_data  = '0;
    start_ok      = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    err_set       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          if (cnt_ok) begin
            start_ok  = 1'b1;
            state_nxt = CONF;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      CONF: begin
        tv_conf_nodes = 1'b1;
        tv_conf_data  = count;
        state_nxt     = LOAD;
      end
      LOAD: begin
        node_ready = 1'b1;
        if (node_valid) begin
          if (node_addr < count) begin
            accept    = 1'b1;
            state_nxt = WR_W;
          end else begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WR_W: begin
        tv_mem_weight = 1'b1;
        tv_mem_addr   = addr_q;
        tv_mem_data   = W_DATA'(word_q[OFF_WEIGHT +: W_WEIGHT]);
        state_nxt     = WR_P;
      end
      WR_P: begin
        tv_mem_par  = 1'b1;
        tv_mem_addr = addr_q;
        tv_mem_data = W_DATA'(word_q[OFF_PARENT +: W_PARENT]);
        state_nxt   = WR_R;
      end
      WR_R: begin
        tv_mem_rew  = 1'b1;
        tv_mem_addr = addr_q;
        tv_mem_data = W_DATA'(word_q[OFF_REWARD +: W_REWARD]);
        state_nxt   = WR_A;
      end
      WR_A: begin
        tv_mem_act  = 1'b1;
        tv_mem_addr = addr_q;
        tv_mem_data = W_DATA'(word_q[OFF_ACTION +: W_ACTION]);
        state_nxt   = (nodes_done == count) ? WAIT : LOAD;
      end
      WAIT: begin
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (hit) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (expire) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      nodes_done <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      res_exp    <= '0;
      res_act    <= '0;
      res_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      res_valid <= capture;
      err       <= err_set;
      if (start_ok) begin
        count      <= cmd_nodes;
        nodes_done <= '0;
      end
      if (accept) begin
        addr_q     <= node_addr;
        word_q     <= node_data;
        nodes_done <= nodes_done + W_ADDR'(1);
      end
      if (capture) begin
        res_exp <= tv_exp;
        res_act <= tv_act;
      end
    end
  end

endmodule
